// File: rtl/tempdivr_pkg.sv
// tempdivr_pkg: shared definitions for the temporary-coefficient RAM sequencer.
// Contents:
//   DEF_RAM_WIDTH / DEF_RAM_ADDR_BITS  default coefficient width and address width
//   OP_*                               command opcode encoding
//   state_t                            sequencer FSM state encoding
package tempdivr_pkg;

  localparam int DEF_RAM_WIDTH     = 13;
  localparam int DEF_RAM_ADDR_BITS = 11;

  localparam logic [1:0] OP_CLEAR      = 2'd0;
  localparam logic [1:0] OP_SHIFT_DOWN = 2'd1;
  localparam logic [1:0] OP_SHIFT_UP   = 2'd2;
  localparam logic [1:0] OP_ROTATE_UP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/tempdivr_seq_if.sv
// tempdivr_seq_if: command handshake and host RAM port of the sequencer.
// Signals:
//   cmd_valid, cmd_op, cmd_len   command request (master -> slave)
//   cmd_ready, done, err         command status (slave -> master)
//   host_we, host_waddr, host_raddr, host_wdata   host RAM access (master -> slave)
//   host_rdata                   host read data (slave -> master)
// Modports: master = host/command side, slave = sequencer.
interface tempdivr_seq_if
  import tempdivr_pkg::*;
#(
  parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
  parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS
) ();

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic [RAM_ADDR_BITS:0]   cmd_len;
  logic                     done;
  logic                     err;
  logic                     host_we;
  logic [RAM_ADDR_BITS-1:0] host_waddr;
  logic [RAM_ADDR_BITS-1:0] host_raddr;
  logic [RAM_WIDTH-1:0]     host_wdata;
  logic [RAM_WIDTH-1:0]     host_rdata;

  modport master (
    output cmd_valid, cmd_op, cmd_len, host_we, host_waddr, host_raddr, host_wdata,
    input  cmd_ready, done, err, host_rdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, host_we, host_waddr, host_raddr, host_wdata,
    output cmd_ready, done, err, host_rdata
  );

endinterface

// File: rtl/tempdivr_port_mux.sv
// tempdivr_port_mux: selects who drives the coefficient RAM port.
// Ports:
//   busy                     1 = sequencer owns the RAM, 0 = host owns it
//   host_we/waddr/raddr/wdata  host request
//   seq_we/waddr/raddr/wdata   sequencer request
//   ram_we/waddr/raddr/wdata   to the RAM
// While busy the host write enable is simply not forwarded, so host writes are dropped.
module tempdivr_port_mux
  import tempdivr_pkg::*;
#(
  parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
  parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS
) (
  input  logic                     busy,
  input  logic                     host_we,
  input  logic [RAM_ADDR_BITS-1:0] host_waddr,
  input  logic [RAM_ADDR_BITS-1:0] host_raddr,
  input  logic [RAM_WIDTH-1:0]     host_wdata,
  input  logic                     seq_we,
  input  logic [RAM_ADDR_BITS-1:0] seq_waddr,
  input  logic [RAM_ADDR_BITS-1:0] seq_raddr,
  input  logic [RAM_WIDTH-1:0]     seq_wdata,
  output logic                     ram_we,
  output logic [RAM_ADDR_BITS-1:0] ram_waddr,
  output logic [RAM_ADDR_BITS-1:0] ram_raddr,
  output logic [RAM_WIDTH-1:0]     ram_wdata
);

  always_comb begin
    if (busy) begin
      ram_we    = seq_we;
      ram_waddr = seq_waddr;
      ram_raddr = seq_raddr;
      ram_wdata = seq_wdata;
    end else begin
      ram_we    = host_we;
      ram_waddr = host_waddr;
      ram_raddr = host_raddr;
      ram_wdata = host_wdata;
    end
  end

endmodule

// File: rtl/tempdivr_seq.sv
// tempdivr_seq: sweep sequencer for the distributed temporary-coefficient RAM
// (synchronous write port, asynchronous read port).
// Commands CLEAR, SHIFT_DOWN (divide by x) and SHIFT_UP (multiply by x) sweep
// the window [0, L-1], one write per cycle. When idle the host port owns the RAM.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   bus          tempdivr_seq_if.slave: command handshake, done/err, host port
//   ram_we, ram_waddr, ram_raddr, ram_wdata, ram_rdata   RAM port
// Build option: define TEMPDIVR_SEQ_ROTATE_EN to enable ROTATE_UP (op 3), which
// uses a PREP cycle to capture the top coefficient. Without it op 3 is illegal.
module tempdivr_seq
  import tempdivr_pkg::*;
#(
  parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
  parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  tempdivr_seq_if.slave            bus,
  output logic                     ram_we,
  output logic [RAM_ADDR_BITS-1:0] ram_waddr,
  output logic [RAM_ADDR_BITS-1:0] ram_raddr,
  output logic [RAM_WIDTH-1:0]     ram_wdata,
  input  logic [RAM_WIDTH-1:0]     ram_rdata
);

  localparam int LW = RAM_ADDR_BITS + 1;
  localparam logic [LW-1:0] MAX_LEN = LW'(1) << RAM_ADDR_BITS;

  state_t                   state_q, state_d;
  logic [1:0]               op_q, op_d;
  logic [LW-1:0]            len_q, len_d;
  logic [RAM_ADDR_BITS-1:0] idx_q, idx_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
`ifdef TEMPDIVR_SEQ_ROTATE_EN
  logic [RAM_WIDTH-1:0]     hold_q, hold_d;
`endif

  logic                     busy;
  logic [LW-1:0]            len_sat;
  logic [LW-1:0]            len_m1;
  logic [RAM_ADDR_BITS-1:0] last_addr;
  logic [RAM_ADDR_BITS-1:0] j_addr;
  logic                     is_last;
  logic                     seq_we;
  logic [RAM_ADDR_BITS-1:0] seq_waddr;
  logic [RAM_ADDR_BITS-1:0] seq_raddr;
  logic [RAM_WIDTH-1:0]     seq_wdata;

  assign busy      = (state_q != ST_IDLE);
  assign len_sat   = (bus.cmd_len > MAX_LEN) ? MAX_LEN : bus.cmd_len;
  assign len_m1    = len_q - LW'(1);
  assign last_addr = len_m1[RAM_ADDR_BITS-1:0];
  // The up-sweeps walk the window from the top so the in-place shift never
  // overwrites a coefficient before it has been read.
  assign j_addr    = last_addr - idx_q;
  assign is_last   = ({1'b0, idx_q} == len_m1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_CLEAR;
      len_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef TEMPDIVR_SEQ_ROTATE_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef TEMPDIVR_SEQ_ROTATE_EN
      hold_q  <= hold_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    len_d     = len_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    err_d     = err_q | (busy & bus.host_we);
`ifdef TEMPDIVR_SEQ_ROTATE_EN
    hold_d    = hold_q;
`endif
    seq_we    = 1'b0;
    seq_waddr = '0;
    seq_raddr = '0;
    seq_wdata = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d  = bus.cmd_op;
          len_d = len_sat;
          idx_d = '0;
`ifndef TEMPDIVR_SEQ_ROTATE_EN
          if (bus.cmd_op == OP_ROTATE_UP) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else
`endif
          if (len_sat == '0) begin
            done_d = 1'b1;
          end else if (bus.cmd_op == OP_ROTATE_UP) begin
            state_d = ST_PREP;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_PREP: begin
`ifdef TEMPDIVR_SEQ_ROTATE_EN
        // Capture the top coefficient; it wraps around into address 0.
        seq_raddr = last_addr;
        hold_d    = ram_rdata;
        state_d   = ST_RUN;
`else
        state_d   = ST_IDLE;
`endif
      end

      ST_RUN: begin
        seq_we = 1'b1;
        case (op_q)
          OP_CLEAR: begin
            seq_waddr = idx_q;
            seq_wdata = '0;
          end
          OP_SHIFT_DOWN: begin
            seq_raddr = idx_q + RAM_ADDR_BITS'(1);
            seq_waddr = idx_q;
            seq_wdata = is_last ? '0 : ram_rdata;
          end
          default: begin
            seq_raddr = j_addr - RAM_ADDR_BITS'(1);
            seq_waddr = j_addr;
            seq_wdata = ram_rdata;
            if (is_last) begin
              seq_wdata = '0;
`ifdef TEMPDIVR_SEQ_ROTATE_EN
              if (op_q == OP_ROTATE_UP) seq_wdata = hold_q;
`endif
            end
          end
        endcase
        if (is_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + RAM_ADDR_BITS'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  tempdivr_port_mux #(
    .RAM_WIDTH    (RAM_WIDTH),
    .RAM_ADDR_BITS(RAM_ADDR_BITS)
  ) u_port_mux (
    .busy      (busy),
    .host_we   (bus.host_we),
    .host_waddr(bus.host_waddr),
    .host_raddr(bus.host_raddr),
    .host_wdata(bus.host_wdata),
    .seq_we    (seq_we),
    .seq_waddr (seq_waddr),
    .seq_raddr (seq_raddr),
    .seq_wdata (seq_wdata),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_raddr (ram_raddr),
    .ram_wdata (ram_wdata)
  );

  assign bus.cmd_ready  = ~busy;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.host_rdata = ram_rdata;

endmodule

// File: doc/tempdivr_seq.md
Name: tempdivr_seq

Overview:
- Sequencer for the 13-bit x 2048 distributed temporary-coefficient RAM used in the reciprocal/division datapath. That RAM has one write port (synchronous write) and one asynchronous read port.
- Runs whole-array sweep commands (clear, shift down = divide by x, shift up = multiply by x) on a coefficient window [0, len-1].
- When idle, passes through a host port that owns the RAM; arbitrates RAM ownership between that port and its own sweep engine.

Parameters:
- RAM_WIDTH, 13, coefficient width (bits)
- RAM_ADDR_BITS, 11, RAM address width; depth = 2**RAM_ADDR_BITS

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=CLEAR, 1=SHIFT_DOWN, 2=SHIFT_UP, 3=ROTATE_UP (optional)
- cmd_len  in  RAM_ADDR_BITS+1  window length in coefficients
- done  out  1  one-cycle pulse at command completion
- err  out  1  sticky; cleared only by reset
- host_we  in  1  host write enable
- host_waddr, host_raddr  in  RAM_ADDR_BITS  host addresses
- host_wdata  in  RAM_WIDTH  host write data
- host_rdata  out  RAM_WIDTH  host read data (= ram_rdata, combinational)
- ram_we  out  1  to RAM write_enable
- ram_waddr, ram_raddr  out  RAM_ADDR_BITS  to RAM addresses
- ram_wdata  out  RAM_WIDTH  to RAM input_data
- ram_rdata  in  RAM_WIDTH  from RAM output_data (asynchronous read)

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, idx=0, hold=0, done=0, err=0, cmd_ready=1. Reset mid-sweep aborts at once; RAM contents are then undefined in the window.
- States are IDLE, PREP and RUN.
  - IDLE -> RUN on cmd_valid for ops 0-2.
  - IDLE -> PREP on cmd_valid for op 3.
  - PREP -> RUN after 1 cycle.
  - RUN -> IDLE after the last write.
- Accept: cmd_valid & cmd_ready at edge T latches op and L.
  - L = min(cmd_len, 2**RAM_ADDR_BITS).
  - If L = 0, no RUN: done pulses in cycle T+1 and the block stays IDLE.
- IDLE muxing: ram_we=host_we, ram_waddr=host_waddr, ram_raddr=host_raddr, ram_wdata=host_wdata.
- Busy (PREP/RUN): host writes are blocked (ram_we driven by the sequencer only). A host_we seen while busy sets err. host_rdata then reflects the sequencer's read address.
- RUN writes exactly one coefficient per cycle, for L cycles (k = 0..L-1):
  - CLEAR: waddr=k, wdata=0.
  - SHIFT_DOWN: for k<L-1, raddr=k+1, waddr=k, wdata=ram_rdata. For k=L-1, waddr=L-1, wdata=0.
  - SHIFT_UP: for j=L-1-k with j>0, raddr=j-1, waddr=j, wdata=ram_rdata. For j=0, waddr=0, wdata=0.
  - Descending order makes in-place shifting safe.
- Latency:
  - Ops 0-2: writes occupy cycles T+1..T+L; done=1 and cmd_ready=1 in cycle T+L+1.
  - Op 3: one extra cycle (PREP).
- Boundaries:
  - L=1 with SHIFT_DOWN or SHIFT_UP writes 0 to address 0.
  - L=2048 covers the full RAM; idx never wraps.
  - Address arithmetic is modulo 2**RAM_ADDR_BITS.
  - cmd_valid while busy is ignored (no queueing).
  - Op 3 without the macro: accepted, no RAM write, err set, done pulses at T+1.

Optional Feature:
- Macro TEMPDIVR_SEQ_ROTATE_EN enables ROTATE_UP (cyclic multiply by x within the window).
- With the macro:
  - PREP sets raddr=L-1 and latches ram_rdata into hold.
  - RUN then behaves as SHIFT_UP, except address 0 receives hold.
  - Total latency is L+2 cycles to done.
- Without the macro: the hold register and PREP state are not synthesized; op 3 is handled as an illegal op (see Behaviour).

Decomposition:
- Package tempdivr_pkg holds:
  - RAM_WIDTH and RAM_ADDR_BITS defaults.
  - The op encoding constants OP_CLEAR, OP_SHIFT_DOWN, OP_SHIFT_UP, OP_ROTATE_UP.
  - The state enum.
- One natural sub-module, tempdivr_port_mux: combinational host/sequencer mux of the RAM port, selected by busy.
- The FSM, counter and hold register stay in tempdivr_seq.

Test Plan:
- Reset, then host writes mem[i]=i+1 for i=0..7 in IDLE -> host_rdata at raddr 5 reads 6; err=0; cmd_ready=1.
- SHIFT_DOWN, L=8, on that data -> done exactly 9 cycles after accept; mem[0..7] = 2,3,4,5,6,7,8,0; mem[8] unchanged.
- SHIFT_UP, L=8, on 1..8 -> mem[0..7] = 0,1,2,3,4,5,6,7.
- CLEAR, L=2048 (cmd_len=4095 saturates) -> 2048 write cycles; all reads 0; done at T+2049.
- Host write and cmd_valid issued mid-sweep:
  - host write is dropped; err goes high and stays high.
  - second command is ignored.
  - rst_n=0 mid-sweep -> next cycle state is IDLE, done=0, err=0.
- With TEMPDIVR_SEQ_ROTATE_EN, ROTATE_UP L=4 on 1,2,3,4 -> mem = 4,1,2,3; done at T+6.
- Without the macro, the same command -> data unchanged; err=1; done at T+1.
